// File: rtl/wasm_fetch.sv
// WebAssembly instruction fetch: pulls a 16-byte ROM window, decodes opcode + LEB128 immediate.
// Optional FETCH_STATS_EN adds a 32-bit accepted-instruction counter. Requires MEM_EXTRA >= 4.
module wasm_fetch #(
  parameter int unsigned MEM_DEPTH = 4,
  parameter int unsigned MEM_EXTRA = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [MEM_DEPTH:0]            start_pc,
  output logic [MEM_DEPTH:0]            mem_addr,
  output logic [MEM_EXTRA-1:0]          mem_extra,
  input  logic [8*(2**MEM_EXTRA)-1:0]   mem_data,
  input  logic                          mem_error,
  output logic                          op_valid,
  input  logic                          op_ready,
  output logic [7:0]                    opcode,
  output logic [63:0]                   imm,
  output logic [MEM_DEPTH:0]            op_pc,
  output logic [3:0]                    trap
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]                   fetch_count
`endif
);

  localparam int unsigned AddrW = MEM_DEPTH + 1;

  typedef enum logic [2:0] {StIdle, StReq, StWait, StDecode, StHold, StTrap} state_e;
  typedef enum logic [1:0] {ImmNone, ImmS32, ImmS64, ImmU32} imm_class_e;

  state_e           state_q, state_d;
  logic [AddrW-1:0] pc_q, pc_d;
  logic [AddrW-1:0] op_pc_q, op_pc_d;
  logic [7:0]       opcode_q, opcode_d;
  logic [63:0]      imm_q, imm_d;
  logic [3:0]       len_q, len_d;
  logic [3:0]       trap_q, trap_d;

  imm_class_e  imm_class;
  logic [3:0]  leb_max;
  logic [69:0] leb_acc;
  logic [3:0]  leb_n;
  logic        leb_done;
  logic        leb_signed;
  logic [3:0]  dec_len;
  logic        dec_overrun;
  logic [63:0] dec_imm;
  logic        accept;

  // Bytes past the longest encoding (opcode + 10 LEB bytes) and acc bits above 63 are never used.
  logic unused_bits;
  assign unused_bits = ^{mem_data[8*(2**MEM_EXTRA)-1:88], leb_acc[69:64]};

  always_comb begin
    imm_class = ImmNone;
    case (mem_data[7:0])
      8'h41:                                           imm_class = ImmS32;
      8'h42:                                           imm_class = ImmS64;
      8'h0C, 8'h0D, 8'h10, 8'h20, 8'h21, 8'h22, 8'h23,
      8'h24:                                           imm_class = ImmU32;
      default:                                         imm_class = ImmNone;
    endcase
  end

  assign leb_signed = (imm_class == ImmS32) || (imm_class == ImmS64);

  // Walk LEB bytes until the first with bit7 clear; sign-extend from that group's bit 6.
  always_comb begin
    leb_max  = (imm_class == ImmS64) ? 4'd10 : 4'd5;
    leb_acc  = '0;
    leb_n    = '0;
    leb_done = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      if (!leb_done && (i <= int'(leb_max))) begin
        leb_acc = leb_acc | (70'(mem_data[8*i +: 7]) << (7 * (i - 1)));
        leb_n   = 4'(i);
        if (!mem_data[8*i+7]) begin
          leb_done = 1'b1;
          if (leb_signed && mem_data[8*i+6]) begin
            leb_acc = leb_acc | ({70{1'b1}} << (7 * i));
          end
        end
      end
    end
  end

  assign dec_len     = (imm_class == ImmNone) ? 4'd1 : leb_n + 4'd1;
  assign dec_overrun = (imm_class != ImmNone) && !leb_done;
  assign dec_imm     = (imm_class == ImmNone) ? 64'd0 : leb_acc[63:0];
  assign accept      = (state_q == StHold) && op_ready && !start;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    op_pc_d  = op_pc_q;
    opcode_d = opcode_q;
    imm_d    = imm_q;
    len_d    = len_q;
    trap_d   = trap_q;
    if (start) begin
      state_d = StReq;
      pc_d    = start_pc;
      trap_d  = 4'd0;
    end else begin
      case (state_q)
        StIdle:   state_d = StIdle;
        StReq:    state_d = StWait;
        StWait:   state_d = StDecode;
        StDecode: begin
          if (mem_error) begin
            trap_d  = 4'd1;
            state_d = StTrap;
          end else if (dec_overrun) begin
            trap_d  = 4'd2;
            state_d = StTrap;
          end else begin
            opcode_d = mem_data[7:0];
            imm_d    = dec_imm;
            op_pc_d  = pc_q;
            len_d    = dec_len;
            state_d  = StHold;
          end
        end
        StHold: begin
          if (accept) begin
            pc_d    = pc_q + AddrW'(len_q);
            state_d = StReq;
          end
        end
        StTrap:   state_d = StTrap;
        default:  state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      pc_q     <= '0;
      op_pc_q  <= '0;
      opcode_q <= '0;
      imm_q    <= '0;
      len_q    <= '0;
      trap_q   <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      op_pc_q  <= op_pc_d;
      opcode_q <= opcode_d;
      imm_q    <= imm_d;
      len_q    <= len_d;
      trap_q   <= trap_d;
    end
  end

  assign mem_addr  = pc_q;
  assign mem_extra = '1;
  assign op_valid  = (state_q == StHold);
  assign opcode    = opcode_q;
  assign imm       = imm_q;
  assign op_pc     = op_pc_q;
  assign trap      = trap_q;

`ifdef FETCH_STATS_EN
  logic [31:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (start) begin
      count_d = '0;
    end else if (accept) begin
      count_d = count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign fetch_count = count_q;
`endif

endmodule
